// File: rtl/pp_accumulator_pkg.sv
// Shared types and default widths for the partial-product accumulator.
package pp_acc_pkg;

    localparam int unsigned PP_W  = 34;
    localparam int unsigned ACC_W = 48;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SUM_W = PP_W + 2;
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DONE
    } acc_state_e;

    typedef logic signed [PP_W-1:0] pp_t;
    typedef pp_t pp_vec_t [LANES];

endpackage

// File: rtl/pp_accumulator_if.sv
// Core-side bus of the accumulator: op control, beat handshake, result handshake.
interface pp_accumulator_if #(
    parameter int unsigned PP_W  = pp_acc_pkg::PP_W,
    parameter int unsigned CNT_W = pp_acc_pkg::CNT_W
);

    logic                   start_i;
    logic [CNT_W-1:0]       num_beats_i;
    logic                   normal_mul_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic signed [PP_W-1:0] partial_prods_i [pp_acc_pkg::LANES];
    logic                   res_valid_o;
    logic                   res_ready_i;
    logic [31:0]            result_o;
    logic                   busy_o;
    logic                   overflow_o;

    modport master (
        output start_i, num_beats_i, normal_mul_i, in_valid_i, partial_prods_i, res_ready_i,
        input  in_ready_o, res_valid_o, result_o, busy_o, overflow_o
    );

    modport slave (
        input  start_i, num_beats_i, normal_mul_i, in_valid_i, partial_prods_i, res_ready_i,
        output in_ready_o, res_valid_o, result_o, busy_o, overflow_o
    );

endinterface

// File: rtl/pp_accumulator_adder_tree.sv
// Combinational signed 4-lane reduction; normal_mul passes lane 0 through alone.
module pp_adder_tree #(
    parameter int unsigned PP_W  = pp_acc_pkg::PP_W,
    parameter int unsigned SUM_W = PP_W + 2
) (
    input  logic signed [PP_W-1:0]  pp [pp_acc_pkg::LANES],
    input  logic                    normal_mul,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [SUM_W-1:0] pair_lo;
    logic signed [SUM_W-1:0] pair_hi;

    always_comb begin
        pair_lo = SUM_W'(pp[0]) + SUM_W'(pp[1]);
        pair_hi = SUM_W'(pp[2]) + SUM_W'(pp[3]);
        sum     = normal_mul ? SUM_W'(pp[0]) : pair_lo + pair_hi;
    end

endmodule

// File: rtl/pp_accumulator.sv
// Dot-product accumulator: input register, registered adder tree, accumulate, result hold.
// Build option PP_ACC_SATURATE_EN clamps the result on overflow instead of wrapping.
module pp_accumulator #(
    parameter int unsigned PP_W  = pp_acc_pkg::PP_W,
    parameter int unsigned ACC_W = pp_acc_pkg::ACC_W,
    parameter int unsigned CNT_W = pp_acc_pkg::CNT_W
) (
    input logic             clk_i,
    input logic             rst_ni,
    pp_accumulator_if.slave bus
);

    import pp_acc_pkg::*;

    localparam int unsigned TREE_W = PP_W + 2;

    acc_state_e               state_q;
    acc_state_e               state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     mode_mul_q;
    logic                     in_valid_q;
    logic signed [PP_W-1:0]   in_pp_q [LANES];
    logic                     s1_valid_q;
    logic signed [TREE_W-1:0] s1_sum_q;
    logic signed [TREE_W-1:0] tree_sum;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     ovf_q;
    logic                     start_op;
    logic                     accept;
    logic                     acc_oor;

    pp_adder_tree #(
        .PP_W  (PP_W),
        .SUM_W (TREE_W)
    ) u_tree (
        .pp         (in_pp_q),
        .normal_mul (mode_mul_q),
        .sum        (tree_sum)
    );

    always_comb begin
        start_op = (state_q == IDLE) && bus.start_i;
        accept   = (state_q == ACCUM) && (cnt_q != '0) && bus.in_valid_i;
        acc_sum  = acc_q + ACC_W'(s1_sum_q);
        acc_oor  = acc_sum[ACC_W-1:31] != {(ACC_W-31){acc_sum[31]}};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = (bus.normal_mul_i || (bus.num_beats_i != '0)) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (accept && (cnt_q == CNT_W'(1))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Input register drained: the sum still in S1 lands in acc on this same edge.
                if (!in_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready_o  = (state_q == ACCUM) && (cnt_q != '0);
        bus.res_valid_o = (state_q == DONE);
        bus.busy_o      = (state_q != IDLE);
        bus.overflow_o  = (state_q == DONE) && ovf_q;
        bus.result_o    = '0;
        if (state_q == DONE) begin
`ifdef PP_ACC_SATURATE_EN
            if (ovf_q) begin
                bus.result_o = acc_q[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                bus.result_o = acc_q[31:0];
            end
`else
            bus.result_o = acc_q[31:0];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            mode_mul_q <= 1'b0;
            in_valid_q <= 1'b0;
            in_pp_q    <= '{default: '0};
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            in_valid_q <= accept;
            if (accept) begin
                in_pp_q <= bus.partial_prods_i;
            end
            s1_valid_q <= in_valid_q;
            if (in_valid_q) begin
                s1_sum_q <= tree_sum;
            end
            if (start_op) begin
                acc_q      <= '0;
                ovf_q      <= 1'b0;
                mode_mul_q <= bus.normal_mul_i;
                cnt_q      <= bus.normal_mul_i ? CNT_W'(1) : bus.num_beats_i;
            end else begin
                if (accept) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                if (s1_valid_q) begin
                    acc_q <= acc_sum;
                    ovf_q <= ovf_q | acc_oor;
                end
            end
        end
    end

endmodule

// File: tb/tb_pp_accumulator.sv
// Self-checking bench for pp_accumulator: transaction-level reference model plus directed cases.
module tb_pp_accumulator;

    import pp_acc_pkg::*;

    localparam longint S32_MAX = 64'sd2147483647;
    localparam longint S32_MIN = -S32_MAX - 1;

`ifdef PP_ACC_SATURATE_EN
    localparam logic [31:0] OVF_LIT = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_LIT = 32'h0000_0000;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    pp_accumulator_if #(.PP_W(PP_W), .CNT_W(CNT_W)) bus ();

    pp_accumulator #(
        .PP_W  (PP_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: one operation at a time, tracked as plain counters and a running sum.
    bit     m_busy  = 1'b0;
    bit     m_done  = 1'b0;
    bit     m_ovf   = 1'b0;
    bit     m_nm    = 1'b0;
    int     m_beats = 0;
    int     m_drain = 0;
    longint m_acc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint beat_value(input pp_vec_t p, input bit nm);
        longint s = 0;
        if (nm) return longint'(p[0]);
        for (int i = 0; i < int'(LANES); i++) s += longint'(p[i]);
        return s;
    endfunction

    function automatic logic [31:0] exp_result(input longint a, input bit ovf);
        logic [63:0] bits;
        bits = a;
`ifdef PP_ACC_SATURATE_EN
        if (ovf) return (a < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (ovf) return bits[31:0];
`endif
        return bits[31:0];
    endfunction

    initial begin : model
        pp_vec_t cur;
        forever begin
            @(posedge clk_i);
            if (!rst_ni) begin
                m_busy = 0; m_done = 0; m_ovf = 0; m_beats = 0; m_drain = 0; m_acc = 0;
            end else if (m_done) begin
                if (bus.res_ready_i) begin
                    m_done = 0;
                    m_busy = 0;
                end
            end else if (!m_busy) begin
                if (bus.start_i) begin
                    m_busy  = 1;
                    m_acc   = 0;
                    m_ovf   = 0;
                    m_drain = 0;
                    m_nm    = bus.normal_mul_i;
                    m_beats = bus.normal_mul_i ? 1 : int'(bus.num_beats_i);
                    if (m_beats == 0) m_done = 1;
                end
            end else begin
                if (m_drain > 0) begin
                    m_drain--;
                    if (m_drain == 0) m_done = 1;
                end
                if (m_beats > 0 && bus.in_valid_i) begin
                    cur   = bus.partial_prods_i;
                    m_acc += beat_value(cur, m_nm);
                    if (m_acc > S32_MAX || m_acc < S32_MIN) m_ovf = 1;
                    m_beats--;
                    if (m_beats == 0) m_drain = 2;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk_i);
            check("busy_o", bus.busy_o, m_busy);
            check("in_ready_o", bus.in_ready_o, m_busy && !m_done && (m_beats > 0));
            check("res_valid_o", bus.res_valid_o, m_done);
            check("result_o", bus.result_o, m_done ? exp_result(m_acc, m_ovf) : 32'h0);
            check("overflow_o", bus.overflow_o, m_done && m_ovf);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic pp_vec_t rand_beat(input int kind);
        pp_vec_t p;
        for (int i = 0; i < int'(LANES); i++) begin
            case (kind)
                0: p[i] = pp_t'(longint'($urandom_range(0, 2097152)) - 64'sd1048576);
                1: p[i] = pp_t'(longint'($urandom));
                default: p[i] = (i == 0) ? pp_t'(longint'(int'($urandom)))
                                         : pp_t'({$urandom, $urandom});
            endcase
        end
        return p;
    endfunction

    task automatic do_start(input int nb, input bit nm);
        int t;
        for (t = 0; t < 200; t++) begin
            if (!bus.busy_o) break;
            @(negedge clk_i);
        end
        if (t == 200) check("idle_timeout", 1'b1, 1'b0);
        bus.start_i      = 1'b1;
        bus.num_beats_i  = CNT_W'(nb);
        bus.normal_mul_i = nm;
        @(negedge clk_i);
        bus.start_i      = 1'b0;
        bus.num_beats_i  = CNT_W'($urandom);
        bus.normal_mul_i = 1'($urandom);
    endtask

    task automatic send_beat(input pp_vec_t p, input bit noise);
        bit rdy;
        int t;
        if (noise) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid_i      = 1'b0;
                bus.partial_prods_i = rand_beat(1);
                bus.start_i         = ($urandom_range(0, 3) == 0);
                @(negedge clk_i);
            end
        end
        bus.in_valid_i      = 1'b1;
        bus.partial_prods_i = p;
        for (t = 0; t < 100; t++) begin
            rdy = bus.in_ready_o;
            @(negedge clk_i);
            if (rdy) break;
            if (noise) bus.start_i = ($urandom_range(0, 3) == 0);
        end
        if (t == 100) check("accept_timeout", 1'b1, 1'b0);
        bus.in_valid_i      = 1'b0;
        bus.start_i         = 1'b0;
        bus.partial_prods_i = rand_beat(1);
    endtask

    task automatic take_result(input int hold, input bit chk_lit, input logic [31:0] lit,
                               input bit lit_ovf);
        int t;
        for (t = 0; t < 50; t++) begin
            if (bus.res_valid_o) break;
            @(negedge clk_i);
        end
        if (t == 50) check("result_timeout", 1'b1, 1'b0);
        if (chk_lit) begin
            check("lit_result", bus.result_o, lit);
            check("lit_overflow", bus.overflow_o, lit_ovf);
        end
        repeat (hold) @(negedge clk_i);
        if (chk_lit) check("lit_result_held", bus.result_o, lit);
        bus.res_ready_i = 1'b1;
        @(negedge clk_i);
        bus.res_ready_i = 1'b0;
    endtask

    initial begin : stimulus
        pp_vec_t p;
        int      kind;
        int      nb;
        bit      nm;

        bus.start_i         = 1'b0;
        bus.num_beats_i     = '0;
        bus.normal_mul_i    = 1'b0;
        bus.in_valid_i      = 1'b0;
        bus.res_ready_i     = 1'b0;
        bus.partial_prods_i = '{default: '0};

        repeat (2) @(negedge clk_i);
        check("reset_busy", bus.busy_o, 1'b0);
        check("reset_result", bus.result_o, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single beat: sum of lanes and pipeline latency.
        do_start(1, 1'b0);
        p = '{34'sd10, 34'sd20, 34'sd30, 34'sd40};
        send_beat(p, 1'b0);
        check("lat_k0", bus.res_valid_o, 1'b0);
        @(negedge clk_i);
        check("lat_k1", bus.res_valid_o, 1'b0);
        @(negedge clk_i);
        check("lat_k2", bus.res_valid_o, 1'b1);
        take_result(0, 1'b1, 32'd100, 1'b0);

        // Four back-to-back beats of all -1.
        do_start(4, 1'b0);
        p = '{-34'sd1, -34'sd1, -34'sd1, -34'sd1};
        repeat (4) send_beat(p, 1'b0);
        take_result(0, 1'b1, 32'hFFFF_FFF0, 1'b0);

        // normal_mul: lane 0 only, one beat regardless of num_beats_i.
        do_start(5, 1'b1);
        p = '{34'sh0_1234_5678, 34'sh3_FFFF_FFFF, 34'sh3_FFFF_FFFF, 34'sh3_FFFF_FFFF};
        send_beat(p, 1'b0);
        take_result(0, 1'b1, 32'h1234_5678, 1'b0);

        // Overflow: 8 beats of 2^31 each.
        do_start(8, 1'b0);
        p = '{34'sd1073741824, 34'sd1073741824, 34'sd0, 34'sd0};
        repeat (8) send_beat(p, 1'b0);
        take_result(0, 1'b1, OVF_LIT, 1'b1);

        // Zero beats: immediate result, held while the consumer stalls.
        do_start(0, 1'b0);
        check("zero_done_next", bus.res_valid_o, 1'b1);
        take_result(5, 1'b1, 32'h0, 1'b0);

        // Reset in the middle of an operation, then a clean operation.
        do_start(4, 1'b0);
        p = '{34'sd100, 34'sd100, 34'sd100, 34'sd100};
        repeat (2) send_beat(p, 1'b0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("midrst_busy", bus.busy_o, 1'b0);
        check("midrst_valid", bus.res_valid_o, 1'b0);
        check("midrst_result", bus.result_o, 32'h0);
        do_start(2, 1'b0);
        p = '{34'sd1, 34'sd2, 34'sd3, 34'sd4};
        send_beat(p, 1'b0);
        p = '{34'sd5, 34'sd6, 34'sd7, 34'sd8};
        send_beat(p, 1'b0);
        take_result(0, 1'b1, 32'd36, 1'b0);

        // Random operations: small signed data, large non-negative data, normal_mul.
        for (int op = 0; op < 40; op++) begin
            kind = $urandom_range(0, 5);
            nm   = (kind == 0);
            nb   = nm ? $urandom_range(1, 6) : $urandom_range(0, 6);
            do_start(nb, nm);
            for (int b = 0; b < (nm ? 1 : nb); b++) begin
                send_beat(rand_beat(nm ? 2 : ((kind <= 2) ? 1 : 0)), 1'b1);
            end
            take_result($urandom_range(0, 3), 1'b0, 32'h0, 1'b0);
        end

        repeat (3) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
